// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper.
// Provides the FSM state encoding, the vector count and the widths used by
// the sweeper top and its settle timer.
package sweep_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int unsigned N_VEC = 16;
   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/settle_timer.sv
// SETTLE-modulo counter that paces each vector of a sweep.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clear    : hold the count at zero (asserted whenever no sweep runs)
//   tick     : high while count = SETTLE-1, i.e. on the sampling cycle
module settle_timer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   logic [3:0] count_q, count_d;

   assign tick = (count_q == 4'(SETTLE - 1));

   always_comb begin
      count_d = count_q + 4'd1;
      if (clear || tick) begin
         count_d = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Stimulus driver and checker for a 4-input combinational function.
// Steps {a,b,c,d} through all 16 vectors, samples f_in after SETTLE cycles
// per vector, and compares the captured truth table with a latched mask.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   start          : sweep request, honoured only in IDLE or DONE
//   expected       : expected truth table, latched when start is accepted
//   f_in           : output of the function under test
//   a, b, c, d     : vector index driven to the function, a = MSB
//   busy, done     : sweep in progress / sweep finished
//   pass           : captured equals expected (valid while done)
//   captured       : sampled truth table
//   fail_mask      : captured ^ expected
//   fail_count     : number of mismatching vectors
//   first_fail     : lowest mismatching vector index (0 if none)
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_VEC-1:0]   expected,
   input  logic               f_in,
   output logic               a,
   output logic               b,
   output logic               c,
   output logic               d,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [N_VEC-1:0]   captured,
   output logic [N_VEC-1:0]   fail_mask,
   output logic [CNT_W-1:0]   fail_count,
   output logic [IDX_W-1:0]   first_fail
);

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_VEC-1:0] exp_q, exp_d;
   logic [N_VEC-1:0] cap_q, cap_d;
   logic [N_VEC-1:0] cap_next;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [IDX_W-1:0] ffail_q, ffail_d;
   logic             pass_q, pass_d;
   logic             tick;
   logic             mismatch;

   // Timer is held at zero outside RUN so every sweep starts a fresh window.
   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q != S_RUN),
      .tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      exp_d    = exp_q;
      cap_d    = cap_q;
      fcnt_d   = fcnt_q;
      ffail_d  = ffail_q;
      pass_d   = pass_q;
      cap_next = cap_q;
      cap_next[idx_q] = f_in;
      mismatch = (f_in != exp_q[idx_q]);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               idx_d   = '0;
               exp_d   = expected;
               cap_d   = '0;
               fcnt_d  = '0;
               ffail_d = '0;
               pass_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (tick) begin
               cap_d = cap_next;
               if (mismatch) begin
                  fcnt_d = fcnt_q + 1'b1;
                  if (fcnt_q == '0) begin
                     ffail_d = idx_q;
                  end
               end
               if (idx_q == IDX_W'(N_VEC - 1)) begin
                  state_d = S_DONE;
                  // Full table including this last sample, so pass is ready with done.
                  pass_d  = (cap_next == exp_q);
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         exp_q   <= '0;
         cap_q   <= '0;
         fcnt_q  <= '0;
         ffail_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exp_q   <= exp_d;
         cap_q   <= cap_d;
         fcnt_q  <= fcnt_d;
         ffail_q <= ffail_d;
         pass_q  <= pass_d;
      end
   end

   // idx is 0 in IDLE (only reachable via reset) and stays at 15 in DONE.
   assign {a, b, c, d} = idx_q;
   assign busy         = (state_q == S_RUN);
   assign done         = (state_q == S_DONE);
   assign pass         = pass_q;
   assign captured     = cap_q;
   assign fail_mask    = cap_q ^ exp_q;
   assign fail_count   = fcnt_q;
   assign first_fail   = ffail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance at SETTLE=1 and one
// at SETTLE=3, each driven by a behavioural model of the function under test.
module tb_truth_table_sweeper;

   // f = POS(maxterms 1,3,6,9,11,13,15): ones everywhere except those indices.
   localparam logic [15:0] MODEL_TAB = 16'h55B5;

   logic        clk = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;

   // SETTLE = 1 instance
   logic        rst1 = 1'b1, start1 = 1'b0, stuck1 = 1'b0;
   logic [15:0] exp1 = '0;
   logic        f1, a1, b1, c1, d1, busy1, done1, pass1;
   logic [15:0] cap1, fmask1;
   logic [4:0]  fcnt1;
   logic [3:0]  ffail1, vec1;

   // SETTLE = 3 instance
   logic        rst3 = 1'b1, start3 = 1'b0;
   logic [15:0] exp3 = '0;
   logic        f3, a3, b3, c3, d3, busy3, done3, pass3;
   logic [15:0] cap3, fmask3;
   logic [4:0]  fcnt3;
   logic [3:0]  ffail3, vec3;
   logic [3:0]  prev3 = '0;
   int          age3 = 0;
   logic [15:0] tab_w;

   always #5 clk = ~clk;

   assign vec1  = {a1, b1, c1, d1};
   assign vec3  = {a3, b3, c3, d3};
   assign tab_w = MODEL_TAB;
   assign f1    = stuck1 ? 1'b0 : tab_w[vec1];

   // Slow model: output is only correct from the second cycle after a change.
   always @(posedge clk) begin
      if (vec3 != prev3) age3 <= 0;
      else if (age3 < 10) age3 <= age3 + 1;
      prev3 <= vec3;
   end
   assign f3 = (vec3 == prev3 && age3 >= 1) ? tab_w[vec3] : ~tab_w[vec3];

   truth_table_sweeper #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .expected(exp1), .f_in(f1),
      .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
      .captured(cap1), .fail_mask(fmask1), .fail_count(fcnt1), .first_fail(ffail1)
   );

   truth_table_sweeper #(.SETTLE(3)) dut3 (
      .clk(clk), .rst(rst3), .start(start3), .expected(exp3), .f_in(f3),
      .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .pass(pass3),
      .captured(cap3), .fail_mask(fmask3), .fail_count(fcnt3), .first_fail(ffail3)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start on dut1 and count the sampled busy cycles (bounded).
   task automatic run_sweep1(input logic [15:0] e, output int len);
      exp1   = e;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      len = 0;
      while (busy1 && len < 200) begin
         len++;
         step();
      end
   endtask

   task automatic check_zero1(input string tag);
      check_eq({tag, "_vec"},   32'(vec1),   32'h0);
      check_eq({tag, "_busy"},  32'(busy1),  32'h0);
      check_eq({tag, "_done"},  32'(done1),  32'h0);
      check_eq({tag, "_pass"},  32'(pass1),  32'h0);
      check_eq({tag, "_cap"},   32'(cap1),   32'h0);
      check_eq({tag, "_fmask"}, 32'(fmask1), 32'h0);
      check_eq({tag, "_fcnt"},  32'(fcnt1),  32'h0);
      check_eq({tag, "_ffail"}, 32'(ffail1), 32'h0);
   endtask

   initial begin
      int len;
      int errs;

      step();
      step();
      check_zero1("rst");
      rst1 = 1'b0;
      rst3 = 1'b0;
      step();

      // Golden pass
      run_sweep1(16'h55B5, len);
      check_eq("gold_len",   32'(len),    32'd16);
      check_eq("gold_done",  32'(done1),  32'h1);
      check_eq("gold_pass",  32'(pass1),  32'h1);
      check_eq("gold_cap",   32'(cap1),   32'h55B5);
      check_eq("gold_fcnt",  32'(fcnt1),  32'h0);
      check_eq("gold_ffail", 32'(ffail1), 32'h0);
      check_eq("gold_vec",   32'(vec1),   32'hF);

      // Reset mid-sweep, then a clean sweep
      exp1   = 16'h55B5;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      repeat (6) step();
      check_eq("mid_busy", 32'(busy1), 32'h1);
      rst1 = 1'b1;
      step();
      check_zero1("midrst");
      rst1 = 1'b0;
      step();
      check_zero1("midrst_idle");
      run_sweep1(16'h55B5, len);
      check_eq("rerun_len",  32'(len),   32'd16);
      check_eq("rerun_pass", 32'(pass1), 32'h1);
      check_eq("rerun_cap",  32'(cap1),  32'h55B5);

      // Injected faults at bits 0 and 10
      run_sweep1(16'h55B4 ^ 16'h0400, len);
      check_eq("inj_done",  32'(done1),  32'h1);
      check_eq("inj_pass",  32'(pass1),  32'h0);
      check_eq("inj_fmask", 32'(fmask1), 32'h0401);
      check_eq("inj_fcnt",  32'(fcnt1),  32'd2);
      check_eq("inj_ffail", 32'(ffail1), 32'd0);

      // Faults at bits 5 and 8: first_fail must be the lowest index
      run_sweep1(16'h55B5 ^ 16'h0120, len);
      check_eq("inj2_fmask", 32'(fmask1), 32'h0120);
      check_eq("inj2_fcnt",  32'(fcnt1),  32'd2);
      check_eq("inj2_ffail", 32'(ffail1), 32'd5);

      // start pulsed during RUN is ignored
      exp1   = 16'h51B4;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      len = 0;
      while (busy1 && len < 200) begin
         start1 = (len == 5);
         len++;
         step();
      end
      start1 = 1'b0;
      check_eq("ign_len",  32'(len),    32'd16);
      check_eq("ign_done", 32'(done1),  32'h1);
      check_eq("ign_fmask", 32'(fmask1), 32'h0401);

      // Back-to-back restart from DONE with a new expected value
      exp1   = 16'h55B5;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check_eq("b2b_busy", 32'(busy1), 32'h1);
      check_eq("b2b_done", 32'(done1), 32'h0);
      check_eq("b2b_pass", 32'(pass1), 32'h0);
      len = 0;
      while (busy1 && len < 200) begin
         len++;
         step();
      end
      check_eq("b2b_len",   32'(len),    32'd16);
      check_eq("b2b_pass2", 32'(pass1),  32'h1);
      check_eq("b2b_fmask", 32'(fmask1), 32'h0);

      // Stuck-at-0 output
      stuck1 = 1'b1;
      run_sweep1(16'hFFFF, len);
      check_eq("stuck_cap",   32'(cap1),   32'h0);
      check_eq("stuck_fcnt",  32'(fcnt1),  32'd16);
      check_eq("stuck_ffail", 32'(ffail1), 32'd0);
      check_eq("stuck_pass",  32'(pass1),  32'h0);
      check_eq("stuck_fmask", 32'(fmask1), 32'hFFFF);
      stuck1 = 1'b0;

      // SETTLE = 3 with a slow-settling model
      check_eq("s3_idle_done", 32'(done3), 32'h0);
      exp3   = 16'h55B5;
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      errs = 0;
      for (int k = 0; k < 48; k++) begin
         if (!busy3 || vec3 != 4'(k / 3)) errs++;
         step();
      end
      check_eq("s3_hold_errs", 32'(errs),  32'd0);
      check_eq("s3_done",      32'(done3), 32'h1);
      check_eq("s3_busy",      32'(busy3), 32'h0);
      check_eq("s3_pass",      32'(pass3), 32'h1);
      check_eq("s3_cap",       32'(cap3),  32'h55B5);
      check_eq("s3_fcnt",      32'(fcnt3), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencing controller that exhaustively exercises a 4-input combinational logic function, such as the team's gate-level `pos`/`sop` blocks. It steps {a,b,c,d} through all 16 input combinations and samples the function output after a programmable settle time. It captures the full truth table, compares it against an expected minterm mask, and reports pass/fail with diagnostics. It sits beside the function-under-test as its stimulus driver and checker on the lab board or in a self-checking top.

## Interface
- `SETTLE`, default 1: cycles each vector is held before `f_in` is sampled; legal range 1–15.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a sweep; accepted only in IDLE or DONE.
- `expected` input 16: expected truth table; bit i is the expected f for vector i; latched on start acceptance.
- `f_in` input 1: output of the function-under-test.
- `a`, `b`, `c`, `d` output 1 each: drive the function-under-test; {a,b,c,d} = vector index, a = MSB.
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: high from sweep completion until the next accepted start or reset.
- `pass` output 1: valid while done; 1 iff captured == latched expected.
- `captured` output 16: sampled truth table; bit i = f_in sampled for vector i.
- `fail_mask` output 16: captured XOR latched expected; combinational from registers.
- `fail_count` output 5: number of mismatching vectors, 0–16.
- `first_fail` output 4: lowest mismatching vector index; 0 when fail_count = 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0, {a,b,c,d}=0. start=1 → latch expected, clear captured/fail_count/first_fail, idx=0, settle count=0, go RUN.
- RUN: busy=1; {a,b,c,d}=idx; settle count increments each cycle.
  - When settle count = SETTLE−1, the edge writes captured[idx] <= f_in.
  - On a mismatch at that edge, fail_count increments. If fail_count was 0, first_fail <= idx.
  - At that edge, if idx=15 → DONE; else idx+1 and settle count cleared.
- DONE: busy=0, done=1, results held; {a,b,c,d} hold 4'hF. start=1 → same actions as in IDLE, go RUN (done drops the next cycle).
- start while in RUN is ignored; start is level-sampled, so no edge detection is performed.
- Reset at any time, including mid-sweep, aborts the sweep and returns to IDLE. It clears all outputs and registers, including the latched expected value.
- Idx wrap does not occur; the sweep terminates at 15.

## Timing
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, captured=0, fail_mask=0, fail_count=0, first_fail=0.
- A start sampled high on edge T0 gives busy=1 and vector 0 driven after T0.
- Vector i is driven for cycles T0+i·SETTLE … T0+(i+1)·SETTLE−1. It is sampled on the last edge of that window.
- done rises on the cycle after the edge at T0+16·SETTLE, giving a sweep latency of 16·SETTLE cycles.
- pass is registered and is valid the same cycle done is high; pass=0 whenever done=0.
- Back-to-back: start held high in DONE restarts with zero idle cycles; done is low for exactly the 16·SETTLE cycles of RUN.

## Structure
- Shared package `sweep_pkg`:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - N_VEC=16;
  - vector index width 4;
  - count width 5.
- One natural sub-module, `settle_timer`, a SETTLE-modulo counter with clear input and `tick` output (tick when count = SETTLE−1). The FSM, capture register and fail tracking stay in the top module.

## Test plan
- Reset mid-sweep: assert rst at cycle 7 of a sweep → next cycle all outputs are 0 and state is IDLE. A subsequent start runs a clean 16-vector sweep.
- Golden pass: use a behavioral model of f = POS(maxterms 1,3,6,9,11,13,15), SETTLE=1, expected=16'h55B5, and pulse start. Expect:
  - busy for exactly 16 cycles;
  - then done=1, pass=1, captured=16'h55B5, fail_count=0, first_fail=0.
- Injected faults: same model, expected=16'h55B4 ^ 16'h0400 (bits 0 and 10 wrong). Expect:
  - pass=0, fail_mask=16'h0401;
  - fail_count=2, first_fail=0.
- Settle timing: SETTLE=3, with a model whose output is only correct 2 cycles after an input change. Expect:
  - pass=1;
  - each vector is held exactly 3 cycles;
  - done rises after 48 cycles.
- Handshake: pulse start during RUN → ignored, no restart, sweep length unchanged. Hold start high in DONE → restart with no idle cycle, and expected is re-latched with the new value.
- Stuck-at output: f_in tied 0, expected=16'hFFFF. Expect captured=0, fail_count=16, first_fail=0, pass=0.
